// File: rtl/aes_round_sched_if.sv
// Job/result handshake and datapath strobe bundle for the AES round scheduler.
// Valid/ready: a transfer happens in every cycle where valid and ready are both high.
interface aes_round_sched_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_key_len;
    logic             dp_load;
    logic             dp_first;
    logic             dp_round_en;
    logic             dp_final;
    logic             dp_ks_step;
    logic [3:0]       dp_round_idx;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [CNT_W-1:0] blk_count;
    logic             err_keylen;
    logic [1:0]       dbg_state;

    modport slave (
        input  in_valid, in_key_len, out_ready,
        output in_ready, dp_load, dp_first, dp_round_en, dp_final, dp_ks_step,
               dp_round_idx, out_valid, busy, blk_count, err_keylen, dbg_state
    );

    modport master (
        output in_valid, in_key_len, out_ready,
        input  in_ready, dp_load, dp_first, dp_round_en, dp_final, dp_ks_step,
               dp_round_idx, out_valid, busy, blk_count, err_keylen, dbg_state
    );
endinterface

// File: rtl/aes_round_sched.sv
// Iterative AES round sequencer: load, round-0 key add, Nr rounds, then hold the
// result until the consumer takes it. Back-to-back jobs skip the IDLE state.
module aes_round_sched #(
    parameter int ROUND_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    aes_round_sched_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_INIT, S_ROUND, S_DONE} state_t;

    localparam logic [3:0] LAST_CYC = 4'(ROUND_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_round;
    logic [3:0]       r_cyc;
    logic [3:0]       r_nr;
    logic [CNT_W-1:0] r_blk_count;
    logic             r_err;

    logic       w_in_ready;
    logic       w_load;
    logic       w_first;
    logic       w_round_en;
    logic       w_final;
    logic       w_out_valid;
    logic       w_out_hs;
    logic [3:0] w_idx;
    logic       w_last_cyc;
    logic       w_last_round;

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            2'd1:    nr_of = 4'd12;
            2'd2:    nr_of = 4'd14;
            default: nr_of = 4'd10;
        endcase
    endfunction

    assign w_last_cyc   = (r_cyc == LAST_CYC);
    assign w_last_round = (r_round == r_nr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   r_state <= S_IDLE;
        else if (clear) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_first     = 1'b0;
        w_round_en  = 1'b0;
        w_final     = 1'b0;
        w_out_valid = 1'b0;
        w_idx       = 4'd0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = S_INIT;
            end
            S_INIT: begin
                w_first     = 1'b1;
                w_state_nxt = S_ROUND;
            end
            S_ROUND: begin
                w_idx = r_round;
                if (w_last_cyc) begin
                    w_round_en = 1'b1;
                    w_final    = w_last_round;
                    if (w_last_round) w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                w_idx       = r_nr;
                w_in_ready  = bus.out_ready;
                if (bus.out_ready) w_state_nxt = bus.in_valid ? S_INIT : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // An abort cycle must not start, strobe or hand off anything.
        if (clear) begin
            w_in_ready  = 1'b0;
            w_first     = 1'b0;
            w_round_en  = 1'b0;
            w_final     = 1'b0;
            w_out_valid = 1'b0;
        end
    end

    assign w_load   = bus.in_valid & w_in_ready;
    assign w_out_hs = w_out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_round     <= 4'd0;
            r_cyc       <= 4'd0;
            r_nr        <= 4'd10;
            r_blk_count <= '0;
            r_err       <= 1'b0;
        end else if (clear) begin
            r_round     <= 4'd0;
            r_cyc       <= 4'd0;
            r_nr        <= 4'd10;
            r_blk_count <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_load) begin
                r_nr <= nr_of(bus.in_key_len);
                if (bus.in_key_len == 2'd3) r_err <= 1'b1;
            end
            if (w_out_hs) r_blk_count <= r_blk_count + 1'b1;
            case (r_state)
                S_INIT: begin
                    r_round <= 4'd1;
                    r_cyc   <= 4'd0;
                end
                S_ROUND: begin
                    if (w_last_cyc) begin
                        r_cyc <= 4'd0;
                        if (!w_last_round) r_round <= r_round + 4'd1;
                    end else begin
                        r_cyc <= r_cyc + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.dp_load      = w_load;
    assign bus.dp_first     = w_first;
    assign bus.dp_round_en  = w_round_en;
    assign bus.dp_final     = w_final;
    assign bus.dp_ks_step   = w_round_en;
    assign bus.dp_round_idx = w_idx;
    assign bus.out_valid    = w_out_valid;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.blk_count    = r_blk_count;
    assign bus.err_keylen   = r_err;
    assign bus.dbg_state    = r_state;
endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: two instances (1 and 3 cycles per round) share one
// stimulus stream and are compared every cycle against a job-timeline model.
module tb_aes_round_sched;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear;
    logic       in_valid;
    logic [1:0] in_key_len;
    logic       out_ready;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int cur_dut  = 0;

    always #5 clk = ~clk;

    aes_round_sched_if #(.CNT_W(16)) if1 ();
    aes_round_sched_if #(.CNT_W(16)) if3 ();

    assign if1.in_valid = in_valid;  assign if3.in_valid = in_valid;
    assign if1.in_key_len = in_key_len;  assign if3.in_key_len = in_key_len;
    assign if1.out_ready = out_ready;  assign if3.out_ready = out_ready;

    aes_round_sched #(.ROUND_CYCLES(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .bus(if1));
    aes_round_sched #(.ROUND_CYCLES(3), .CNT_W(16)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .bus(if3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s dut=%0d cyc=%0d got=%0h exp=%0h", tag, cur_dut, cyc, got, exp);
    endtask

    // Reference model: each job is a timeline measured from its load cycle.
    bit          m_act[2];
    int          m_t0[2];
    int          m_nr[2];
    logic [15:0] m_blk[2];
    logic        m_err[2];
    int          cnt_ren[2];
    int          cnt_fin[2];
    int          t_load[2];
    int          lat_nr[2];
    logic        prev_ov[2];
    logic [3:0]  exp_q0[$];
    logic [3:0]  exp_q1[$];

    function automatic int nr_of(input logic [1:0] kl);
        return (kl == 2'd3) ? 10 : 10 + 2 * int'(kl);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 0; m_blk[d] = '0; m_err[d] = 1'b0;
            cnt_ren[d] = 0; cnt_fin[d] = 0; prev_ov[d] = 1'b0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic check_dut(input int d, input int rc, input logic ir, input logic ld,
                             input logic fi, input logic ren, input logic ks, input logic fin,
                             input logic [3:0] idx, input logic ov, input logic bsy,
                             input logic [15:0] blk, input logic err, input logic [1:0] st);
        int p, len, k, n;
        logic e_ir, e_ld, e_fi, e_ren, e_fin, e_ov, e_bsy;
        int e_idx, e_st;
        e_ir = 0; e_fi = 0; e_ren = 0; e_fin = 0; e_ov = 0; e_bsy = 0; e_idx = 0; e_st = 0;
        cur_dut = d;
        if (!m_act[d]) begin
            e_ir = 1;
        end else begin
            p = cyc - m_t0[d];
            len = 1 + m_nr[d] * rc;
            e_bsy = 1;
            if (p == 1) begin
                e_fi = 1; e_st = 1;
            end else if (p <= len) begin
                k = p - 2;
                e_idx = k / rc + 1;
                e_ren = ((k % rc) == rc - 1);
                e_fin = e_ren && (e_idx == m_nr[d]);
                e_st = 2;
            end else begin
                e_ov = 1; e_idx = m_nr[d]; e_ir = out_ready; e_st = 3;
            end
        end
        if (clear) begin
            e_ir = 0; e_fi = 0; e_ren = 0; e_fin = 0; e_ov = 0;
        end
        e_ld = in_valid & e_ir;

        check("in_ready", 32'(ir), 32'(e_ir));
        check("dp_load", 32'(ld), 32'(e_ld));
        check("dp_first", 32'(fi), 32'(e_fi));
        check("dp_round_en", 32'(ren), 32'(e_ren));
        check("dp_ks_step", 32'(ks), 32'(e_ren));
        check("dp_final", 32'(fin), 32'(e_fin));
        check("dp_round_idx", 32'(idx), 32'(e_idx));
        check("out_valid", 32'(ov), 32'(e_ov));
        check("busy", 32'(bsy), 32'(e_bsy));
        check("blk_count", 32'(blk), 32'(m_blk[d]));
        check("err_keylen", 32'(err), 32'(m_err[d]));
        check("dbg_state", 32'(st), 32'(e_st));

        // Scoreboard: per job, the number of round commits and final strobes.
        if (clear) begin
            if (d == 0) exp_q0.delete(); else exp_q1.delete();
            cnt_ren[d] = 0; cnt_fin[d] = 0;
        end else begin
            if (ren) cnt_ren[d]++;
            if (fin) cnt_fin[d]++;
            if (ov && !prev_ov[d]) check("latency", cyc - t_load[d], 2 + lat_nr[d] * rc);
            if (ov && out_ready) begin
                if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                    check("sb_empty", 32'd0, 32'd1);
                end else begin
                    n = (d == 0) ? int'(exp_q0.pop_front()) : int'(exp_q1.pop_front());
                    check("round_pulses", cnt_ren[d], n);
                    check("final_pulses", cnt_fin[d], 1);
                end
            end
            if (ld) begin
                if (d == 0) exp_q0.push_back(4'(nr_of(in_key_len)));
                else        exp_q1.push_back(4'(nr_of(in_key_len)));
                cnt_ren[d] = 0; cnt_fin[d] = 0;
                t_load[d] = cyc; lat_nr[d] = nr_of(in_key_len);
            end
        end
        prev_ov[d] = clear ? 1'b0 : ov;

        if (clear) begin
            m_act[d] = 0; m_blk[d] = '0; m_err[d] = 1'b0;
        end else begin
            if (e_ov && out_ready) m_blk[d] = m_blk[d] + 16'd1;
            if (e_ld) begin
                m_act[d] = 1; m_t0[d] = cyc; m_nr[d] = nr_of(in_key_len);
                if (in_key_len == 2'd3) m_err[d] = 1'b1;
            end else if (e_ov && out_ready) begin
                m_act[d] = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            check_dut(0, 1, if1.in_ready, if1.dp_load, if1.dp_first, if1.dp_round_en,
                      if1.dp_ks_step, if1.dp_final, if1.dp_round_idx, if1.out_valid,
                      if1.busy, if1.blk_count, if1.err_keylen, if1.dbg_state);
            check_dut(1, 3, if3.in_ready, if3.dp_load, if3.dp_first, if3.dp_round_en,
                      if3.dp_ks_step, if3.dp_final, if3.dp_round_idx, if3.out_valid,
                      if3.busy, if3.blk_count, if3.err_keylen, if3.dbg_state);
        end
        cyc++;
    end

    // Applies inputs just after a rising edge and holds them for n cycles.
    task automatic drive(input logic iv, input logic [1:0] kl, input logic orr,
                         input logic clr, input int n);
        in_valid = iv; in_key_len = kl; out_ready = orr; clear = clr;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        cur_dut = 0;
        check({tag, ".busy"}, 32'(if1.busy), 32'd0);
        check({tag, ".out_valid"}, 32'(if1.out_valid), 32'd0);
        check({tag, ".round_en"}, 32'(if1.dp_round_en), 32'd0);
        check({tag, ".idx"}, 32'(if1.dp_round_idx), 32'd0);
        check({tag, ".blk"}, 32'(if1.blk_count), 32'd0);
        cur_dut = 1;
        check({tag, ".busy"}, 32'(if3.busy), 32'd0);
        check({tag, ".out_valid"}, 32'(if3.out_valid), 32'd0);
        check({tag, ".blk"}, 32'(if3.blk_count), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_key_len = 2'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check_quiet("reset");
        cur_dut = 0;
        check("reset.err", 32'(if1.err_keylen), 32'd0);
        check("reset.in_ready", 32'(if1.in_ready), 32'd1);

        // Single jobs of each legal key length with the consumer always ready.
        drive(1, 2'd0, 1, 0, 1); drive(0, 2'd0, 1, 0, 60);
        drive(1, 2'd2, 1, 0, 1); drive(0, 2'd0, 1, 0, 60);
        drive(1, 2'd1, 1, 0, 1); drive(0, 2'd0, 1, 0, 60);
        cur_dut = 0;
        check("blk_after_3", 32'(if1.blk_count), 32'd3);

        // Backpressure in DONE, then an output handshake that also loads a new job.
        drive(1, 2'd1, 0, 0, 1); drive(0, 2'd0, 0, 0, 60);
        drive(1, 2'd0, 1, 0, 1); drive(0, 2'd0, 1, 0, 60);

        // Continuous stream with the key length changing every cycle.
        for (int i = 0; i < 150; i++) drive(1, 2'($urandom_range(0, 2)), 1, 0, 1);
        drive(0, 2'd0, 1, 0, 60);

        // Illegal key length is sticky across a legal job and cleared by clear.
        drive(1, 2'd3, 1, 0, 1); drive(0, 2'd0, 1, 0, 60);
        drive(1, 2'd0, 1, 0, 1); drive(0, 2'd0, 1, 0, 60);
        cur_dut = 1;
        check("err_sticky", 32'(if3.err_keylen), 32'd1);
        drive(0, 2'd0, 1, 1, 1); drive(0, 2'd0, 1, 0, 1);
        check("err_cleared", 32'(if3.err_keylen), 32'd0);

        // Abort mid-round by clear, then by an asynchronous reset pulse.
        drive(1, 2'd0, 1, 0, 1); drive(0, 2'd0, 1, 0, 6);
        drive(0, 2'd0, 1, 1, 1);
        check_quiet("clear");
        drive(1, 2'd0, 1, 0, 1); drive(0, 2'd0, 1, 0, 60);
        drive(1, 2'd0, 1, 0, 1); drive(0, 2'd0, 1, 0, 7);
        #1 reset_n = 1'b0;
        #1 check_quiet("async_rst");
        @(posedge clk); #1 reset_n = 1'b1;
        drive(1, 2'd0, 1, 0, 1); drive(0, 2'd0, 1, 0, 60);

        // Random traffic with occasional backpressure and aborts.
        for (int i = 0; i < 1500; i++)
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0), 1);
        drive(0, 2'd0, 1, 0, 60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
